part_dpram_param: RTL and testbench

- Parametrised single-clock, true dual-port synchronous SRAM. Next generation of the fixed 2kx17 DRAM-backing RAM.
- Adds the following over the fixed part:
  - configurable width and depth
  - a hardware zero-fill sequencer, replacing simulation-only initial blocks
  - a defined read-during-write policy
  - cross-port write-collision arbitration with a sticky flag
  - an optional output register stage and per-port read-valid strobes
- Used by DRAM and by any future map/page tables.

---
 rtl/dpram_pkg.sv | 12 +
 rtl/part_dpram_init_seq.sv | 52 +++++
 rtl/part_dpram_param.sv | 192 +++++++++++++++++++
 tb/tb_part_dpram_param.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared constants and types for the parametrised dual-port RAM.
package dpram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/part_dpram_init_seq.sv
// Zero-fill sequencer: walks every address once after reset, then parks in RUN.
module part_dpram_init_seq
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic                  fill_we,
    output logic                  init_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    seq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: state_d = RUN;
        endcase
    end

    // init_done comes straight from the state flop, so it rises the cycle after the last fill write.
    always_comb begin
        fill_addr = cnt_q;
        fill_we   = (state_q == INIT);
        init_done = (state_q == RUN);
    end

endmodule

// File: rtl/part_dpram_param.sv
// Parametrised single-clock true dual-port RAM with hardware zero-fill,
// selectable read-during-write policy, A-wins write arbitration and optional output register.
module part_dpram_param
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = 17,
    parameter int ADDR_WIDTH = 11,
    parameter int OUT_REG    = 0,
    parameter int RDW_MODE   = 0
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  wren_a,
    input  logic                  rden_a,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic                  valid_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  wren_b,
    input  logic                  rden_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  valid_b,
    output logic                  init_done,
    output logic                  collision,
    input  logic                  clear_collision
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  run;
    logic                  fill_we;
    logic [ADDR_WIDTH-1:0] fill_addr;

    part_dpram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .clk       (clk),
        .reset_n   (reset_n),
        .fill_addr (fill_addr),
        .fill_we   (fill_we),
        .init_done (run)
    );

    assign init_done = run;

    logic                  same_addr;
    logic                  wr_en_a, wr_en_b;
    logic [ADDR_WIDTH-1:0] wr_addr_a;
    logic [DATA_WIDTH-1:0] wr_data_a;

    assign same_addr = (address_a == address_b);

    // Port A's write path doubles as the fill path while the sequencer is busy.
    always_comb begin
        wr_en_a   = 1'b0;
        wr_en_b   = 1'b0;
        wr_addr_a = address_a;
        wr_data_a = data_a;
        if (!run) begin
            wr_en_a   = fill_we;
            wr_addr_a = fill_addr;
            wr_data_a = '0;
        end else begin
            wr_en_a = wren_a;
            wr_en_b = wren_b && !(wren_a && same_addr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_b) mem[address_b] <= data_b;
        if (wr_en_a) mem[wr_addr_a] <= wr_data_a;
    end

    logic collision_q, collision_d, coll_set;

    assign coll_set = run && wren_a && wren_b && same_addr;

    always_comb begin
        collision_d = collision_q;
        if (coll_set)             collision_d = 1'b1;
        else if (clear_collision) collision_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) collision_q <= 1'b0;
        else          collision_q <= collision_d;
    end

    assign collision = collision_q;

    logic [1:0][ADDR_WIDTH-1:0] port_addr;
    logic [1:0]                 port_rden;
    logic [1:0][DATA_WIDTH-1:0] port_q;
    logic [1:0]                 port_valid;

    assign port_addr = {address_b, address_a};
    assign port_rden = {rden_b, rden_a};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic                  rd_en;
            logic                  fwd_hit;
            logic [DATA_WIDTH-1:0] fwd_val;
            logic [DATA_WIDTH-1:0] ram_rd_q;
            logic                  fwd_sel_q, fwd_sel_d;
            logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
            logic                  valid_s1_q, valid_s1_d;
            logic [DATA_WIDTH-1:0] rd_data;

            assign rd_en = run && port_rden[gi];

            // Checking A first makes the forwarded word follow the A-wins rule.
            always_comb begin
                fwd_hit = 1'b0;
                fwd_val = data_a;
                if (wren_a && (address_a == port_addr[gi])) begin
                    fwd_hit = 1'b1;
                    fwd_val = data_a;
                end else if (wren_b && (address_b == port_addr[gi])) begin
                    fwd_hit = 1'b1;
                    fwd_val = data_b;
                end
            end

            always_ff @(posedge clk) begin
                if (rd_en) ram_rd_q <= mem[port_addr[gi]];
            end

            always_comb begin
                fwd_sel_d  = fwd_sel_q;
                fwd_data_d = fwd_data_q;
                valid_s1_d = rd_en;
                if (rd_en) begin
                    fwd_sel_d  = (RDW_MODE == RDW_WRITE_FIRST) && fwd_hit;
                    fwd_data_d = fwd_val;
                end
            end

            // Reset selects the forward register holding zero, so q reads 0 without resetting the RAM output.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    fwd_sel_q  <= 1'b1;
                    fwd_data_q <= '0;
                    valid_s1_q <= 1'b0;
                end else begin
                    fwd_sel_q  <= fwd_sel_d;
                    fwd_data_q <= fwd_data_d;
                    valid_s1_q <= valid_s1_d;
                end
            end

            assign rd_data = fwd_sel_q ? fwd_data_q : ram_rd_q;

            if (OUT_REG != 0) begin : g_oreg
                logic [DATA_WIDTH-1:0] q_out_q, q_out_d;
                logic                  valid_out_q, valid_out_d;

                always_comb begin
                    q_out_d     = valid_s1_q ? rd_data : q_out_q;
                    valid_out_d = valid_s1_q;
                end

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        q_out_q     <= '0;
                        valid_out_q <= 1'b0;
                    end else begin
                        q_out_q     <= q_out_d;
                        valid_out_q <= valid_out_d;
                    end
                end

                assign port_q[gi]     = q_out_q;
                assign port_valid[gi] = valid_out_q;
            end else begin : g_noreg
                assign port_q[gi]     = rd_data;
                assign port_valid[gi] = valid_s1_q;
            end
        end
    endgenerate

    assign q_a     = port_q[0];
    assign valid_a = port_valid[0];
    assign q_b     = port_q[1];
    assign valid_b = port_valid[1];

endmodule

// File: tb/tb_part_dpram_param.sv
// Bench for part_dpram_param: four instances covering OUT_REG x RDW_MODE, one shared stimulus.
module tb_part_dpram_param;

    localparam int DW    = 17;
    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;
    localparam int NDUT  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [AW-1:0] address_a, address_b;
    logic [DW-1:0] data_a, data_b;
    logic          wren_a, rden_a, wren_b, rden_b, clear_collision;

    logic [DW-1:0] q_a_w [NDUT];
    logic [DW-1:0] q_b_w [NDUT];
    logic          valid_a_w [NDUT];
    logic          valid_b_w [NDUT];
    logic          init_done_w [NDUT];
    logic          collision_w [NDUT];

    // Instance k: OUT_REG = k/2, RDW_MODE = k%2.
    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            part_dpram_param #(
                .DATA_WIDTH (DW),
                .ADDR_WIDTH (AW),
                .OUT_REG    (gi / 2),
                .RDW_MODE   (gi % 2)
            ) u_dut (
                .clk             (clk),
                .reset_n         (reset_n),
                .address_a       (address_a),
                .data_a          (data_a),
                .wren_a          (wren_a),
                .rden_a          (rden_a),
                .q_a             (q_a_w[gi]),
                .valid_a         (valid_a_w[gi]),
                .address_b       (address_b),
                .data_b          (data_b),
                .wren_b          (wren_b),
                .rden_b          (rden_b),
                .q_b             (q_b_w[gi]),
                .valid_b         (valid_b_w[gi]),
                .init_done       (init_done_w[gi]),
                .collision       (collision_w[gi]),
                .clear_collision (clear_collision)
            );
        end
    endgenerate

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", name, k, act, exp, $time);
        end
    endtask

    // Reference model: memory contents, fill progress, and per-instance expected outputs.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_fill;
    logic          m_run, m_coll;
    logic [DW-1:0] e_qa [NDUT], e_qb [NDUT], p_qa [NDUT], p_qb [NDUT];
    logic          e_va [NDUT], e_vb [NDUT], p_va [NDUT], p_vb [NDUT];

    task automatic model_reset();
        m_fill = 0;
        m_run  = 1'b0;
        m_coll = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            e_qa[k] = '0; e_qb[k] = '0; p_qa[k] = '0; p_qb[k] = '0;
            e_va[k] = 1'b0; e_vb[k] = 1'b0; p_va[k] = 1'b0; p_vb[k] = 1'b0;
        end
    endtask

    // Old data = memory before this edge, new data = memory after both writes land.
    task automatic model_step();
        logic [DW-1:0] old_a, old_b, new_a, new_b, d_a, d_b;
        logic          va, vb;
        if (!reset_n) return;
        old_a = '0; old_b = '0; new_a = '0; new_b = '0;
        va = 1'b0; vb = 1'b0;
        if (!m_run) begin
            m_mem[m_fill] = '0;
            if (m_fill == DEPTH - 1) m_run = 1'b1;
            else                     m_fill++;
        end else begin
            old_a = m_mem[address_a];
            old_b = m_mem[address_b];
            if (wren_b) m_mem[address_b] = data_b;
            if (wren_a) m_mem[address_a] = data_a;
            new_a = m_mem[address_a];
            new_b = m_mem[address_b];
            if (wren_a && wren_b && address_a == address_b) m_coll = 1'b1;
            else if (clear_collision)                       m_coll = 1'b0;
            va = rden_a;
            vb = rden_b;
        end
        for (int k = 0; k < NDUT; k++) begin
            d_a = (k % 2 == 1) ? new_a : old_a;
            d_b = (k % 2 == 1) ? new_b : old_b;
            if (k / 2 == 0) begin
                e_va[k] = va; if (va) e_qa[k] = d_a;
                e_vb[k] = vb; if (vb) e_qb[k] = d_b;
            end else begin
                e_va[k] = p_va[k]; if (p_va[k]) e_qa[k] = p_qa[k];
                e_vb[k] = p_vb[k]; if (p_vb[k]) e_qb[k] = p_qb[k];
                p_va[k] = va; if (va) p_qa[k] = d_a;
                p_vb[k] = vb; if (vb) p_qb[k] = d_b;
            end
        end
    endtask

    task automatic compare_model();
        for (int k = 0; k < NDUT; k++) begin
            chk("m_qa",   k, q_a_w[k],       e_qa[k]);
            chk("m_va",   k, valid_a_w[k],   e_va[k]);
            chk("m_qb",   k, q_b_w[k],       e_qb[k]);
            chk("m_vb",   k, valid_b_w[k],   e_vb[k]);
            chk("m_coll", k, collision_w[k], m_coll);
            chk("m_init", k, init_done_w[k], m_run);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int k = 0; k < NDUT; k++) begin
            chk({name, "_qa"},   k, q_a_w[k],       0);
            chk({name, "_qb"},   k, q_b_w[k],       0);
            chk({name, "_va"},   k, valid_a_w[k],   0);
            chk({name, "_vb"},   k, valid_b_w[k],   0);
            chk({name, "_init"}, k, init_done_w[k], 0);
            chk({name, "_coll"}, k, collision_w[k], 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        wren_a = 1'b0; rden_a = 1'b0; wren_b = 1'b0; rden_b = 1'b0; clear_collision = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
            compare_model();
        end while (!init_done_w[0] && n < DEPTH + 8);
        chk(name, 0, n, DEPTH);
    endtask

    typedef struct {
        logic          wa, ra;
        logic [AW-1:0] aa;
        logic [DW-1:0] da;
        logic          wb, rb;
        logic [AW-1:0] ab;
        logic [DW-1:0] db;
        logic          clr;
        logic [DW-1:0] qa_rf, qa_wf, qb_rf, qb_wf;
        logic          coll;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vt [NVEC];

    task automatic check_rd(input int i, input int k);
        chk($sformatf("tbl%0d_va", i), k, valid_a_w[k], vt[i].ra);
        chk($sformatf("tbl%0d_vb", i), k, valid_b_w[k], vt[i].rb);
        if (vt[i].ra) chk($sformatf("tbl%0d_qa", i), k, q_a_w[k], (k % 2 == 1) ? vt[i].qa_wf : vt[i].qa_rf);
        if (vt[i].rb) chk($sformatf("tbl%0d_qb", i), k, q_b_w[k], (k % 2 == 1) ? vt[i].qb_wf : vt[i].qb_rf);
    endtask

    initial begin
        //          wa    ra    aa        da         wb    rb    ab        db         clr   qa_rf      qa_wf      qb_rf      qb_wf      coll
        vt[0]  = '{1'b1, 1'b0, 12'o0345, 17'h1ABCD, 1'b0, 1'b0, 12'd0,    17'h00000, 1'b0, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 12'd0,    17'h00000, 1'b0, 1'b1, 12'o0345, 17'h00000, 1'b0, 17'h00000, 17'h00000, 17'h1ABCD, 17'h1ABCD, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 12'd5,    17'h00011, 1'b0, 1'b0, 12'd0,    17'h00000, 1'b0, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 12'd5,    17'h00022, 1'b0, 1'b0, 12'd0,    17'h00000, 1'b0, 17'h00011, 17'h00022, 17'h00000, 17'h00000, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 12'd5,    17'h00033, 1'b0, 1'b1, 12'd5,    17'h00000, 1'b0, 17'h00000, 17'h00000, 17'h00022, 17'h00033, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 12'd6,    17'h00000, 1'b1, 1'b0, 12'd6,    17'h00044, 1'b0, 17'h00000, 17'h00044, 17'h00000, 17'h00000, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 12'd6,    17'h1FFFF, 1'b0, 1'b1, 12'd6,    17'h1EEEE, 1'b0, 17'h00000, 17'h00000, 17'h00044, 17'h00044, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 12'd7,    17'h00AAA, 1'b1, 1'b0, 12'd7,    17'h00BBB, 1'b0, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 12'd7,    17'h00000, 1'b0, 1'b1, 12'd7,    17'h00000, 1'b0, 17'h00AAA, 17'h00AAA, 17'h00AAA, 17'h00AAA, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 12'd0,    17'h00000, 1'b0, 1'b0, 12'd0,    17'h00000, 1'b1, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 1'b0};
        vt[10] = '{1'b1, 1'b0, 12'd7,    17'h00CCC, 1'b1, 1'b0, 12'd7,    17'h00DDD, 1'b1, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 1'b1};
        vt[11] = '{1'b0, 1'b1, 12'd7,    17'h00000, 1'b0, 1'b0, 12'd0,    17'h00000, 1'b1, 17'h00CCC, 17'h00CCC, 17'h00000, 17'h00000, 1'b0};
        vt[12] = '{1'b1, 1'b0, 12'd8,    17'h00123, 1'b1, 1'b0, 12'd9,    17'h00456, 1'b0, 17'h00000, 17'h00000, 17'h00000, 17'h00000, 1'b0};
        vt[13] = '{1'b0, 1'b1, 12'd8,    17'h00000, 1'b0, 1'b1, 12'd9,    17'h00000, 1'b0, 17'h00123, 17'h00123, 17'h00456, 17'h00456, 1'b0};
        vt[14] = '{1'b1, 1'b1, 12'd7,    17'h00E01, 1'b1, 1'b1, 12'd7,    17'h00E02, 1'b0, 17'h00CCC, 17'h00E01, 17'h00CCC, 17'h00E01, 1'b1};

        reset_n = 1'b0;
        idle();
        address_a = '0; address_b = '0; data_a = '0; data_b = '0;
        model_reset();
        repeat (3) tick();
        check_all_zero("reset");

        // Port traffic during the fill must be ignored and produce no valid strobes.
        wren_a = 1'b1; rden_a = 1'b1; address_a = 12'd3; data_a = 17'h1FFFF;
        wren_b = 1'b1; rden_b = 1'b1; address_b = 12'd3; data_b = 17'h15555;
        reset_n = 1'b1;
        wait_init("init_cycles");
        idle();

        for (int i = 0; i < DEPTH; i++) begin
            rden_a = 1'b1; address_a = AW'(i);
            rden_b = 1'b1; address_b = AW'(DEPTH - 1 - i);
            tick();
            compare_model();
        end
        idle();
        repeat (2) begin tick(); compare_model(); end

        for (int i = 0; i < NVEC; i++) begin
            wren_a = vt[i].wa; rden_a = vt[i].ra; address_a = vt[i].aa; data_a = vt[i].da;
            wren_b = vt[i].wb; rden_b = vt[i].rb; address_b = vt[i].ab; data_b = vt[i].db;
            clear_collision = vt[i].clr;
            tick();
            for (int k = 0; k < NDUT; k++) chk($sformatf("tbl%0d_coll", i), k, collision_w[k], vt[i].coll);
            check_rd(i, 0);
            check_rd(i, 1);
            idle();
            tick();
            check_rd(i, 2);
            check_rd(i, 3);
        end

        // Reset from RUN with live outputs and the collision flag set.
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (9) begin tick(); compare_model(); end
        reset_n = 1'b0;
        #1;
        check_all_zero("midinit_rst");
        model_reset();
        tick();
        reset_n = 1'b1;
        wait_init("reinit_cycles");

        rden_b = 1'b1; address_b = 12'o0345;
        tick();
        compare_model();
        chk("prewrite_cleared_q", 0, q_b_w[0], 0);
        chk("prewrite_cleared_v", 0, valid_b_w[0], 1);
        idle();
        tick();
        compare_model();
        chk("prewrite_cleared_q", 2, q_b_w[2], 0);
        chk("prewrite_cleared_v", 2, valid_b_w[2], 1);

        for (int c = 0; c < 10000; c++) begin
            wren_a = 1'($urandom_range(0, 1));
            rden_a = 1'($urandom_range(0, 1));
            wren_b = 1'($urandom_range(0, 1));
            rden_b = 1'($urandom_range(0, 1));
            clear_collision = ($urandom_range(0, 15) == 0);
            address_a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 15));
            address_b = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 15));
            data_a = DW'($urandom());
            data_b = DW'($urandom());
            tick();
            compare_model();
        end
        idle();
        repeat (3) begin tick(); compare_model(); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
